// File: rtl/kmeans_pkg.sv
// Shared constants for the k-means assignment stage: PointOps opcodes,
// controller states and the double-precision word width.
package kmeans_pkg;

  localparam int DBL_W = 64;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_DIST = 4'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIST = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/kmeans_centroid_regs.sv
// K-entry centroid table: one synchronous write port and one combinational read port.
// A read and a write to the same entry in one cycle returns the old contents.
module kmeans_centroid_regs
  import kmeans_pkg::*;
#(
  parameter int K    = 4,
  parameter int IDXW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [IDXW-1:0]  wr_idx_i,
  input  logic [DBL_W-1:0] wr_x_i,
  input  logic [DBL_W-1:0] wr_y_i,
  input  logic [IDXW-1:0]  rd_idx_i,
  output logic [DBL_W-1:0] rd_x_o,
  output logic [DBL_W-1:0] rd_y_o
);

  logic [DBL_W-1:0] x_all [K];
  logic [DBL_W-1:0] y_all [K];

  // Indices >= K never match any entry, so such writes are dropped.
  for (genvar gi = 0; gi < K; gi++) begin : g_ent
    logic [DBL_W-1:0] x_q;
    logic [DBL_W-1:0] y_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        x_q <= '0;
        y_q <= '0;
      end else if (wr_en_i && (wr_idx_i == IDXW'(gi))) begin
        x_q <= wr_x_i;
        y_q <= wr_y_i;
      end
    end

    assign x_all[gi] = x_q;
    assign y_all[gi] = y_q;
  end

  assign rd_x_o = x_all[rd_idx_i];
  assign rd_y_o = y_all[rd_idx_i];

endmodule

// File: rtl/kmeans_nearest_centroid.sv
// k-means assignment step: walks all centroids through an external PointOps
// (SUB then DIST per centroid) and reports the nearest index and its distance.
module kmeans_nearest_centroid
  import kmeans_pkg::*;
#(
  parameter int K    = 4,
  parameter int IDXW = ($clog2(K) > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_cwr_en,
  input  logic [IDXW-1:0]  io_cwr_idx,
  input  logic [DBL_W-1:0] io_cwr_x,
  input  logic [DBL_W-1:0] io_cwr_y,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [DBL_W-1:0] io_in_x,
  input  logic [DBL_W-1:0] io_in_y,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [IDXW-1:0]  io_out_idx,
  output logic [DBL_W-1:0] io_out_dist,
  output logic             io_busy,
  output logic [3:0]       io_po_op,
  output logic [DBL_W-1:0] io_po_p1x,
  output logic [DBL_W-1:0] io_po_p1y,
  output logic [DBL_W-1:0] io_po_p2x,
  output logic [DBL_W-1:0] io_po_p2y,
  output logic [DBL_W-1:0] io_po_den,
  input  logic [DBL_W-1:0] io_po_poutx,
  input  logic [DBL_W-1:0] io_po_pouty,
  input  logic [DBL_W-1:0] io_po_out
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  bidx_q, bidx_d;
  logic [DBL_W-1:0] px_q, px_d, py_q, py_d;
  logic [DBL_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [DBL_W-1:0] best_q, best_d;
  logic [DBL_W-1:0] cent_x, cent_y;

  kmeans_centroid_regs #(.K(K), .IDXW(IDXW)) u_cregs (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en_i  (io_cwr_en),
    .wr_idx_i (io_cwr_idx),
    .wr_x_i   (io_cwr_x),
    .wr_y_i   (io_cwr_y),
    .rd_idx_i (idx_q),
    .rd_x_o   (cent_x),
    .rd_y_o   (cent_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bidx_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      best_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      best_q  <= best_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bidx_d    = bidx_q;
    px_d      = px_q;
    py_d      = py_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    best_d    = best_q;
    io_po_op  = OP_NOP;
    io_po_p1x = '0;
    io_po_p1y = '0;
    io_po_p2x = '0;
    io_po_p2y = '0;
    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          px_d    = io_in_x;
          py_d    = io_in_y;
          idx_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        io_po_op  = OP_SUB;
        io_po_p1x = px_q;
        io_po_p1y = py_q;
        io_po_p2x = cent_x;
        io_po_p2y = cent_y;
        dx_d      = io_po_poutx;
        dy_d      = io_po_pouty;
        state_d   = DIST;
      end
      DIST: begin
        io_po_op  = OP_DIST;
        io_po_p1x = dx_q;
        io_po_p1y = dy_q;
        // Non-negative doubles order like unsigned integers; NaNs sort above all finites.
        if (idx_q == '0 || io_po_out < best_q) begin
          best_d = io_po_out;
          bidx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SUB;
        end
      end
      DONE: begin
        if (io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_in_ready  = (state_q == IDLE);
  assign io_out_valid = (state_q == DONE);
  assign io_busy      = (state_q != IDLE);
  assign io_out_idx   = bidx_q;
  assign io_out_dist  = best_q;
  assign io_po_den    = '0;

endmodule

// File: tb/tb_kmeans_nearest_centroid.sv
// Bench for kmeans_nearest_centroid: real-math PointOps model, directed cases
// and randomized points checked against a floating-point nearest-centroid model.
module tb_kmeans_nearest_centroid;
  import kmeans_pkg::*;

  localparam int K    = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            io_cwr_en;
  logic [IDXW-1:0] io_cwr_idx;
  logic [63:0]     io_cwr_x, io_cwr_y;
  logic            io_in_valid, io_in_ready;
  logic [63:0]     io_in_x, io_in_y;
  logic            io_out_valid, io_out_ready;
  logic [IDXW-1:0] io_out_idx;
  logic [63:0]     io_out_dist;
  logic            io_busy;
  logic [3:0]      io_po_op;
  logic [63:0]     io_po_p1x, io_po_p1y, io_po_p2x, io_po_p2y, io_po_den;
  logic [63:0]     io_po_poutx, io_po_pouty, io_po_out;

  int  n_total = 0;
  int  n_bad   = 0;
  real cx [K];
  real cy [K];

  always #5 clk = ~clk;

  kmeans_nearest_centroid #(.K(K)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_cwr_en    (io_cwr_en),
    .io_cwr_idx   (io_cwr_idx),
    .io_cwr_x     (io_cwr_x),
    .io_cwr_y     (io_cwr_y),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_x      (io_in_x),
    .io_in_y      (io_in_y),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_idx   (io_out_idx),
    .io_out_dist  (io_out_dist),
    .io_busy      (io_busy),
    .io_po_op     (io_po_op),
    .io_po_p1x    (io_po_p1x),
    .io_po_p1y    (io_po_p1y),
    .io_po_p2x    (io_po_p2x),
    .io_po_p2y    (io_po_p2y),
    .io_po_den    (io_po_den),
    .io_po_poutx  (io_po_poutx),
    .io_po_pouty  (io_po_pouty),
    .io_po_out    (io_po_out)
  );

  // Combinational PointOps stand-in using the simulator's double arithmetic.
  always_comb begin
    io_po_poutx = '0;
    io_po_pouty = '0;
    io_po_out   = '0;
    case (io_po_op)
      OP_ADD: begin
        io_po_poutx = $realtobits($bitstoreal(io_po_p1x) + $bitstoreal(io_po_p2x));
        io_po_pouty = $realtobits($bitstoreal(io_po_p1y) + $bitstoreal(io_po_p2y));
      end
      OP_SUB: begin
        io_po_poutx = $realtobits($bitstoreal(io_po_p1x) - $bitstoreal(io_po_p2x));
        io_po_pouty = $realtobits($bitstoreal(io_po_p1y) - $bitstoreal(io_po_p2y));
      end
      OP_DIST: begin
        io_po_out = $realtobits($sqrt(
          ($bitstoreal(io_po_p1x) - $bitstoreal(io_po_p2x)) *
          ($bitstoreal(io_po_p1x) - $bitstoreal(io_po_p2x)) +
          ($bitstoreal(io_po_p1y) - $bitstoreal(io_po_p2y)) *
          ($bitstoreal(io_po_p1y) - $bitstoreal(io_po_p2y))));
      end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nearest(input real px, input real py, output int bi, output logic [63:0] bd);
    real best, d;
    best = 0.0;
    bi   = 0;
    for (int i = 0; i < K; i++) begin
      d = $sqrt((px - cx[i]) * (px - cx[i]) + (py - cy[i]) * (py - cy[i]));
      if (i == 0 || d < best) begin
        best = d;
        bi   = i;
      end
    end
    bd = $realtobits(best);
  endtask

  task automatic load_cent(input int idx, input real x, input real y);
    @(negedge clk);
    io_cwr_en  = 1'b1;
    io_cwr_idx = IDXW'(idx);
    io_cwr_x   = $realtobits(x);
    io_cwr_y   = $realtobits(y);
    @(negedge clk);
    io_cwr_en = 1'b0;
    if (idx < K) begin
      cx[idx] = x;
      cy[idx] = y;
    end
  endtask

  // wr_cyc / rst_cyc count clock edges after the accepting edge; -1 disables them.
  task automatic do_point(input string tag, input real px, input real py, input int stall,
                          input int wr_cyc, input int wr_idx, input real wx, input real wy,
                          input int rst_cyc);
    int          exp_idx;
    logic [63:0] exp_dist;
    int          cnt;
    logic        saw;
    nearest(px, py, exp_idx, exp_dist);
    @(negedge clk);
    check_val({tag, ".in_ready"}, 64'(io_in_ready), 64'(1'b1));
    io_in_valid = 1'b1;
    io_in_x     = $realtobits(px);
    io_in_y     = $realtobits(py);
    @(negedge clk);
    io_in_valid = 1'b0;
    cnt = 0;
    while (!io_out_valid && cnt < 4 * K + 4) begin
      if (cnt == 0) begin
        check_val({tag, ".sub_op"}, 64'(io_po_op), 64'(OP_SUB));
        check_val({tag, ".sub_p2x"}, io_po_p2x, $realtobits(cx[0]));
        check_val({tag, ".busy"}, 64'(io_busy), 64'(1'b1));
        check_val({tag, ".in_ready_busy"}, 64'(io_in_ready), 64'(1'b0));
      end
      if (cnt == 1) begin
        check_val({tag, ".dist_op"}, 64'(io_po_op), 64'(OP_DIST));
        check_val({tag, ".den"}, io_po_den, 64'h0);
      end
      if (cnt == wr_cyc) begin
        io_cwr_en  = 1'b1;
        io_cwr_idx = IDXW'(wr_idx);
        io_cwr_x   = $realtobits(wx);
        io_cwr_y   = $realtobits(wy);
      end
      if (cnt == rst_cyc) begin
        reset_n   = 1'b0;
        io_cwr_en = 1'b0;
        #1;
        check_val({tag, ".rst_valid"}, 64'(io_out_valid), 64'(1'b0));
        check_val({tag, ".rst_ready"}, 64'(io_in_ready), 64'(1'b1));
        check_val({tag, ".rst_busy"}, 64'(io_busy), 64'(1'b0));
        check_val({tag, ".rst_idx"}, 64'(io_out_idx), 64'h0);
        check_val({tag, ".rst_dist"}, io_out_dist, 64'h0);
        check_val({tag, ".rst_op"}, 64'(io_po_op), 64'(OP_NOP));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < K; i++) begin
          cx[i] = 0.0;
          cy[i] = 0.0;
        end
        saw = 1'b0;
        repeat (2 * K + 4) begin
          @(negedge clk);
          if (io_out_valid) saw = 1'b1;
        end
        check_val({tag, ".no_out_valid"}, 64'(saw), 64'(1'b0));
        $display("txn %s pt=(%f,%f) aborted by reset", tag, px, py);
        return;
      end
      @(negedge clk);
      cnt++;
      if (cnt == wr_cyc + 1) begin
        io_cwr_en = 1'b0;
        if (wr_idx < K) begin
          cx[wr_idx] = wx;
          cy[wr_idx] = wy;
        end
      end
    end
    check_val({tag, ".latency"}, 64'(cnt), 64'(2 * K));
    check_val({tag, ".idx"}, 64'(io_out_idx), 64'(exp_idx));
    check_val({tag, ".dist"}, io_out_dist, exp_dist);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val({tag, ".hold_valid"}, 64'(io_out_valid), 64'(1'b1));
      check_val({tag, ".hold_idx"}, 64'(io_out_idx), 64'(exp_idx));
      check_val({tag, ".hold_dist"}, io_out_dist, exp_dist);
      check_val({tag, ".hold_in_ready"}, 64'(io_in_ready), 64'(1'b0));
    end
    io_out_ready = 1'b1;
    @(negedge clk);
    io_out_ready = 1'b0;
    check_val({tag, ".post_valid"}, 64'(io_out_valid), 64'(1'b0));
    check_val({tag, ".post_in_ready"}, 64'(io_in_ready), 64'(1'b1));
    $display("txn %s pt=(%f,%f) idx=%0d dist=%h exp_idx=%0d exp_dist=%h",
             tag, px, py, io_out_idx, io_out_dist, exp_idx, exp_dist);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real rx, ry;
    reset_n      = 1'b0;
    io_cwr_en    = 1'b0;
    io_cwr_idx   = '0;
    io_cwr_x     = '0;
    io_cwr_y     = '0;
    io_in_valid  = 1'b0;
    io_in_x      = '0;
    io_in_y      = '0;
    io_out_ready = 1'b0;
    for (int i = 0; i < K; i++) begin
      cx[i] = 0.0;
      cy[i] = 0.0;
    end
    repeat (3) @(negedge clk);
    check_val("reset.out_valid", 64'(io_out_valid), 64'(1'b0));
    check_val("reset.in_ready", 64'(io_in_ready), 64'(1'b1));
    check_val("reset.busy", 64'(io_busy), 64'(1'b0));
    check_val("reset.out_idx", 64'(io_out_idx), 64'h0);
    check_val("reset.out_dist", io_out_dist, 64'h0);
    check_val("reset.po_op", 64'(io_po_op), 64'(OP_NOP));
    check_val("reset.po_p1x", io_po_p1x, 64'h0);
    reset_n = 1'b1;

    load_cent(0, 0.0, 0.0);
    load_cent(1, 3.0, 4.0);
    load_cent(2, 10.0, 0.0);
    load_cent(3, 1.0, 1.0);
    do_point("exact_hit", 3.0, 4.0, 0, -1, 0, 0.0, 0.0, -1);
    do_point("sqrt2", 9.0, 1.0, 0, -1, 0, 0.0, 0.0, -1);

    load_cent(0, 0.0, 0.0);
    load_cent(1, 10.0, 0.0);
    load_cent(2, 10.0, 0.0);
    load_cent(3, 20.0, 0.0);
    do_point("tie_stall", 5.0, 0.0, 3, -1, 0, 0.0, 0.0, -1);

    do_point("wr_in_sub", 5.0, 0.0, 0, 6, 3, 5.0, 0.0, -1);
    do_point("wr_after", 5.0, 0.0, 1, -1, 0, 0.0, 0.0, -1);

    do_point("rst_dist1", 3.0, 4.0, 0, -1, 0, 0.0, 0.0, 3);
    load_cent(0, 0.0, 0.0);
    load_cent(1, 3.0, 4.0);
    load_cent(2, 10.0, 0.0);
    load_cent(3, 1.0, 1.0);
    do_point("after_rst", 9.0, 1.0, 0, -1, 0, 0.0, 0.0, -1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        rx = (real'(int'($urandom_range(0, 80))) - 40.0) / 2.0;
        ry = (real'(int'($urandom_range(0, 80))) - 40.0) / 2.0;
        load_cent(int'($urandom_range(0, K - 1)), rx, ry);
      end
      rx = (real'(int'($urandom_range(0, 160))) - 80.0) / 4.0;
      ry = (real'(int'($urandom_range(0, 160))) - 80.0) / 4.0;
      do_point($sformatf("rnd%0d", t), rx, ry, int'($urandom_range(0, 3)),
               -1, 0, 0.0, 0.0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
